// File: rtl/moore_pattern_tx.sv
// Serial pattern transmitter: latches a W-bit pattern and repeat count on start,
// then shifts copies out MSB-first, optionally overlapping OVL bits between copies.
module moore_pattern_tx #(
  parameter int W   = 4,
  parameter int OVL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] pattern_in,
  input  logic [3:0]   count_in,
  input  logic         overlap_in,
  output logic         data,
  output logic         data_valid,
  output logic         busy,
  output logic         done
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] TOP     = IW'(W - 1);
  localparam logic [IW-1:0] TOP_OVL = IW'(W - 1 - OVL);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t         state;
  logic [W-1:0]   pat;
  logic [3:0]     cnt;
  logic           ovl;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  reload;

  always_comb begin
    reload = ovl ? TOP_OVL : TOP;
  end

  // Outputs are loaded together with the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pat        <= '0;
      cnt        <= '0;
      ovl        <= 1'b0;
      idx        <= '0;
      data       <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data       <= 1'b0;
          data_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            pat  <= pattern_in;
            cnt  <= count_in;
            ovl  <= overlap_in;
            idx  <= TOP;
            busy <= 1'b1;
            if (count_in != 4'd0) begin
              state      <= SEND;
              data       <= pattern_in[W-1];
              data_valid <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (idx != '0) begin
            idx  <= idx - IW'(1);
            data <= pat[idx - IW'(1)];
          end else if (cnt > 4'd1) begin
            cnt  <= cnt - 4'd1;
            idx  <= reload;
            data <= pat[reload];
          end else begin
            state      <= DONE;
            data       <= 1'b0;
            data_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          data       <= 1'b0;
          data_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Bench for moore_pattern_tx: expected output streams come from a bit-list model
// built directly from pattern, count and overlap.
module tb_moore_pattern_tx;
  localparam int W   = 4;
  localparam int OVL = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] pattern_in;
  logic [3:0]   count_in;
  logic         overlap_in;
  logic         data, data_valid, busy, done;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];   // per cycle: {data, data_valid, busy, done}

  always #5 clk = ~clk;

  moore_pattern_tx #(.W(W), .OVL(OVL)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern_in(pattern_in),
    .count_in(count_in), .overlap_in(overlap_in), .data(data),
    .data_valid(data_valid), .busy(busy), .done(done)
  );

  function automatic int n_bits(input int c, input bit ov);
    if (c == 0) return 0;
    return ov ? W + (c - 1) * (W - OVL) : W * c;
  endfunction

  // Bits of every copy, then the DONE cycle, then one IDLE cycle.
  function automatic void build_exp(input logic [W-1:0] p, input int c, input bit ov);
    exp_q.delete();
    for (int k = 0; k < c; k++) begin
      int first = (k > 0 && ov) ? W - 1 - OVL : W - 1;
      for (int b = first; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0});
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endfunction

  task automatic launch(input logic [W-1:0] p, input logic [3:0] c, input bit ov);
    @(negedge clk);
    start = 1'b1; pattern_in = p; count_in = c; overlap_in = ov;
    build_exp(p, int'(c), ov);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; pattern_in = 4'b1111; count_in = 4'd5; overlap_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({data, data_valid, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got %b exp 0000", i, {data, data_valid, busy, done});
      end
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({data, data_valid, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b exp 0000", i, {data, data_valid, busy, done});
      end
    end
  endtask

  // One complete transfer with inputs scrambled after the start cycle.
  task automatic test_transfer(input string name, input logic [W-1:0] p,
                               input logic [3:0] c, input bit ov);
    int nv = 0;
    int nb = 0;
    launch(p, c, ov);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start = 1'b0; pattern_in = W'($urandom); count_in = 4'($urandom); overlap_in = 1'($urandom);
      checks++;
      if ({data, data_valid, busy, done} !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cyc %0d got %b exp %b", name, i, {data, data_valid, busy, done}, exp_q[i]);
      end
      nv += int'(data_valid);
      nb += int'(busy);
    end
    checks++;
    if (nv != n_bits(int'(c), ov) || nb != n_bits(int'(c), ov) + 1) begin
      errors++;
      $display("FAIL %s_len valid=%0d busy=%0d exp valid=%0d busy=%0d",
               name, nv, nb, n_bits(int'(c), ov), n_bits(int'(c), ov) + 1);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++)
      test_transfer("random", W'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] dp;
    logic [3:0]   dc;
    logic         dov;
    bit           got = 0;
    launch(4'b1011, 4'd2, 1'b1);
    dp = pattern_in; dc = count_in; dov = overlap_in;
    for (int i = 0; i < exp_q.size() - 1; i++) begin
      @(negedge clk);
      checks++;
      if ({data, data_valid, busy, done} !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_first cyc %0d got %b exp %b", i, {data, data_valid, busy, done}, exp_q[i]);
      end
      dp = W'($urandom); dc = 4'($urandom_range(1, 3)); dov = 1'($urandom);
      pattern_in = dp; count_in = dc; overlap_in = dov;
    end
    for (int g = 0; g < 4 && !got; g++) begin
      @(negedge clk);
      if (data_valid) begin
        got = 1;
      end else begin
        checks++;
        if ({data, busy, done} !== 3'b000) begin
          errors++;
          $display("FAIL b2b_gap cyc %0d got %b exp 000", g, {data, busy, done});
        end
        dp = W'($urandom); dc = 4'($urandom_range(1, 3)); dov = 1'($urandom);
        pattern_in = dp; count_in = dc; overlap_in = dov;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_restart got no second transfer exp data_valid=1 within 4 cycles");
    end else begin
      start = 1'b0;
      build_exp(dp, int'(dc), dov);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if ({data, data_valid, busy, done} !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_second cyc %0d got %b exp %b", i, {data, data_valid, busy, done}, exp_q[i]);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    launch(4'b1101, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({data, data_valid, busy, done} !== exp_q[i]) begin
        errors++;
        $display("FAIL rstmid_pre cyc %0d got %b exp %b", i, {data, data_valid, busy, done}, exp_q[i]);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({data, data_valid, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL rstmid_after cyc %0d got %b exp 0000", i, {data, data_valid, busy, done});
      end
    end
    test_transfer("rstmid_new", 4'b0110, 4'd2, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern_in = '0; count_in = '0; overlap_in = 1'b0;
    test_reset();
    test_transfer("single", 4'b1001, 4'd1, 1'b0);
    test_transfer("rep_noovl", 4'b1001, 4'd3, 1'b0);
    test_transfer("rep_ovl", 4'b1001, 4'd3, 1'b1);
    test_transfer("count0", 4'b1111, 4'd0, 1'b1);
    test_transfer("count15", 4'b1010, 4'd15, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
